// File: rtl/wb_dp_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_dp_ram_port_arbiter
//
// 2:1 round-robin arbiter that lets two pipelined Wishbone masters (for
// example a CPU data bus and a DMA engine) share one port of the Wishbone
// dual-port RAM wrapper.
//
// A grant is held for a whole bus cycle, that is for as long as the granted
// master keeps cyc high. Accepted but not yet acknowledged transfers are
// counted. When a master drops cyc with transfers still in flight, the
// arbiter drains them before the RAM port is handed to anyone else.
//
// Arbitration
//   - IDLE with one requester: that master is granted.
//   - IDLE with both requesters: the master that was not granted last wins.
//   - The grant decision is registered, so a master's first stb reaches
//     s_stb_o one cycle after its cyc is sampled.
//   - Every hand-over passes through IDLE for one cycle.
//
// Parameters
//   ADDR_WIDTH       word-address width, identical to the RAM port
//   MAX_OUTSTANDING  maximum number of accepted-but-unacked transfers (>= 1)
//   TIMEOUT_CYCLES   ack watchdog limit (only used with WB_ARB_TIMEOUT_EN)
//
// Optional feature
//   WB_ARB_TIMEOUT_EN  when defined, an ack watchdog is built in.
//     - It counts cycles with transfers in flight and no ack/err.
//     - On expiry in a grant state it pulses err to the granted master and
//       clears the in-flight count.
//     - On expiry in DRAIN it clears the count and returns to IDLE.
//     When undefined there is no watchdog, and a missing ack holds the grant
//     indefinitely.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   mN_adr_i/dat_i/we_i/sel_i         master N request (N = 0, 1)
//   mN_stb_i/cyc_i                    master N strobe / cycle
//   mN_dat_o/ack_o/err_o              master N response (granted master only)
//   mN_stall_o                        master N stall (1 while not granted)
//   s_adr_o/dat_o/we_o/sel_o          request towards the RAM port
//   s_stb_o/cyc_o                     strobe / cycle towards the RAM port
//   s_dat_i/stall_i/ack_i/err_i       response from the RAM port
// ---------------------------------------------------------------------------
module wb_dp_ram_port_arbiter #(
    parameter int ADDR_WIDTH      = 14,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    // master 0
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]           m0_dat_i,
    output logic [31:0]           m0_dat_o,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_stall_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    // master 1
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]           m1_dat_i,
    output logic [31:0]           m1_dat_o,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_stall_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    // RAM port
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_stall_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]       state_q,       state_d;
    logic             last_grant_q,  last_grant_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic gnt0;         // master 0 owns the RAM port
    logic gnt1;         // master 1 owns the RAM port
    logic draining;     // waiting for in-flight acks with no owner
    logic full;         // no room for another accepted transfer
    logic busy;         // at least one transfer in flight
    logic accept;       // RAM port takes a transfer this cycle
    logic resp;         // RAM port returns ack or err this cycle
    logic resp_valid;   // response that matches an in-flight transfer
    logic timeout_hit;  // watchdog expires this cycle

    assign gnt0       = (state_q == ST_GRANT0);
    assign gnt1       = (state_q == ST_GRANT1);
    assign draining   = (state_q == ST_DRAIN);
    assign full       = (outstanding_q == CNT_MAX);
    assign busy       = (outstanding_q != '0);
    assign resp       = s_ack_i | s_err_i;
    assign resp_valid = resp & busy;
    assign accept     = s_stb_o & ~s_stall_i;

    // -----------------------------------------------------------------------
    // Request path towards the RAM and response steering back to the masters
    // -----------------------------------------------------------------------
    // NOTE: every signal driven from an always_comb gets a value on every
    // path (here a plain default) so that no latch is inferred.
    always_comb begin
        // The request fields simply follow master 1 while it is granted and
        // master 0 otherwise; they are qualified by s_stb_o / s_cyc_o.
        s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
        s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
        s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
        s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;

        // cyc stays high in the cycle where the owner drops it with
        // transfers still in flight, so the RAM never sees a one-cycle gap
        // between the grant and the following DRAIN.
        s_cyc_o = draining
                | (gnt0 & (m0_cyc_i | busy))
                | (gnt1 & (m1_cyc_i | busy));

        // A full in-flight window blocks new strobes from reaching the RAM.
        s_stb_o = ~full & ((gnt0 & m0_cyc_i & m0_stb_i)
                         | (gnt1 & m1_cyc_i & m1_stb_i));

        m0_stall_o = ~gnt0 | s_stall_i | full;
        m1_stall_o = ~gnt1 | s_stall_i | full;

        // Responses go only to the current owner. In IDLE and DRAIN they are
        // absorbed here.
        m0_ack_o = gnt0 & s_ack_i;
        m1_ack_o = gnt1 & s_ack_i;
        m0_err_o = gnt0 & (s_err_i | timeout_hit);
        m1_err_o = gnt1 & (s_err_i | timeout_hit);
        m0_dat_o = gnt0 ? s_dat_i : '0;
        m1_dat_o = gnt1 ? s_dat_i : '0;
    end

    // -----------------------------------------------------------------------
    // Optional ack watchdog
    // -----------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_run;

    always_comb begin
        // Count waiting cycles. On the TIMEOUT_CYCLES-th consecutive cycle
        // without a response the watchdog fires in that same cycle.
        wd_run      = (gnt0 | gnt1 | draining) & busy & ~resp;
        timeout_hit = wd_run & (wd_q == WD_LAST);
        wd_d        = (wd_run & ~timeout_hit) ? wd_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // In-flight counter and arbitration FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // Simultaneous accept and response leave the count unchanged.
        // A response with nothing in flight is ignored, so the count cannot
        // underflow. A full window cannot overflow, because s_stb_o is held
        // low while full.
        outstanding_d = outstanding_q;
        if (accept && !resp_valid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && resp_valid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        // On a watchdog expiry, everything in flight is written off. A
        // transfer accepted in the same cycle is still counted.
        if (timeout_hit) begin
            outstanding_d = CNT_W'(accept);
        end

        state_d      = state_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Contention: the master that was not granted last wins.
                    state_d      = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                    last_grant_d = ~last_grant_q;
                end else if (m0_cyc_i) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                end
            end

            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    state_d = (outstanding_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end

            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    state_d = (outstanding_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (outstanding_d == '0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments, so every
    // flop samples the values that were stable before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_wb_dp_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for wb_dp_ram_port_arbiter.
//
// Timing
//   - Inputs change 1 time unit after each rising clock edge.
//   - Outputs are compared 1 time unit later, well before the next edge.
//
// Scenarios
//   reset state, single read, round-robin contention, a pipelined burst
//   that fills the in-flight window, drain with absorbed acks, a stray ack,
//   and a reset during a burst.
//   The watchdog scenario is compiled in only with WB_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_wb_dp_ram_port_arbiter;

    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic          m0_we_i, m1_we_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic          m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o;
    logic          m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o, s_dat_i;
    logic          s_we_o, s_stb_o, s_cyc_o;
    logic [3:0]    s_sel_o;
    logic          s_stall_i, s_ack_i, s_err_i;

    int n_cmp = 0;
    int n_bad = 0;

    wb_dp_ram_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_adr_i   (m0_adr_i),
        .m0_dat_i   (m0_dat_i),
        .m0_dat_o   (m0_dat_o),
        .m0_we_i    (m0_we_i),
        .m0_sel_i   (m0_sel_i),
        .m0_stb_i   (m0_stb_i),
        .m0_cyc_i   (m0_cyc_i),
        .m0_stall_o (m0_stall_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_adr_i   (m1_adr_i),
        .m1_dat_i   (m1_dat_i),
        .m1_dat_o   (m1_dat_o),
        .m1_we_i    (m1_we_i),
        .m1_sel_i   (m1_sel_i),
        .m1_stb_i   (m1_stb_i),
        .m1_cyc_i   (m1_cyc_i),
        .m1_stall_o (m1_stall_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_stb_o    (s_stb_o),
        .s_cyc_o    (s_cyc_o),
        .s_dat_i    (s_dat_i),
        .s_stall_i  (s_stall_i),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Moves to the start of the next cycle's drive window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of the m1 burst: the stimulus driven in that cycle and the
    // outputs expected in the same cycle.
    typedef struct packed {
        logic          stb;
        logic [AW-1:0] adr;
        logic          ack;
        logic          x_stall;
        logic          x_stb;
        logic          x_ack;
    } beat_t;

    beat_t burst[11];

    initial begin
        // RAM ack latency is 4 cycles, so the 4-deep window fills first.
        burst = '{
            '{1'b1, 14'h100, 1'b0, 1'b0, 1'b1, 1'b0},  // accept 1
            '{1'b1, 14'h101, 1'b0, 1'b0, 1'b1, 1'b0},  // accept 2
            '{1'b1, 14'h102, 1'b0, 1'b0, 1'b1, 1'b0},  // accept 3
            '{1'b1, 14'h103, 1'b0, 1'b0, 1'b1, 1'b0},  // accept 4 -> full
            '{1'b1, 14'h104, 1'b1, 1'b1, 1'b0, 1'b1},  // full: stalled, ack 1
            '{1'b1, 14'h104, 1'b1, 1'b0, 1'b1, 1'b1},  // accept 5, ack 2
            '{1'b1, 14'h105, 1'b1, 1'b0, 1'b1, 1'b1},  // accept 6, ack 3
            '{1'b0, 14'h105, 1'b1, 1'b0, 1'b0, 1'b1},  // ack 4
            '{1'b0, 14'h105, 1'b0, 1'b0, 1'b0, 1'b0},  // gap
            '{1'b0, 14'h105, 1'b1, 1'b0, 1'b0, 1'b1},  // ack 5
            '{1'b0, 14'h105, 1'b1, 1'b0, 1'b0, 1'b1}   // ack 6
        };

        rst = 1'b1;
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = 4'hF;
        m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
        s_dat_i = '0; s_stall_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        check("rst_s_cyc",    s_cyc_o,    1'b0);
        check("rst_s_stb",    s_stb_o,    1'b0);
        check("rst_m0_stall", m0_stall_o, 1'b1);
        check("rst_m1_stall", m1_stall_o, 1'b1);
        check("rst_m0_ack",   m0_ack_o,   1'b0);
        check("rst_m1_err",   m1_err_o,   1'b0);

        // ---------------- 1: single m0 read ----------------
        tick(); rst = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 14'h0010; m0_we_i = 1'b0; #1;
        check("t1_idle_stb",      s_stb_o,    1'b0);
        check("t1_idle_m0_stall", m0_stall_o, 1'b1);
        tick(); #1;
        check("t1_s_stb",         s_stb_o,    1'b1);
        check_word("t1_s_adr",    {18'b0, s_adr_o}, 32'h0000_0010);
        check("t1_s_we",          s_we_o,     1'b0);
        check("t1_m0_stall",      m0_stall_o, 1'b0);
        check("t1_m1_stall_a",    m1_stall_o, 1'b1);
        tick(); m0_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; #1;
        check("t1_m0_ack",        m0_ack_o,   1'b1);
        check_word("t1_m0_dat",   m0_dat_o,   32'hDEAD_BEEF);
        check("t1_m1_ack",        m1_ack_o,   1'b0);
        check("t1_m1_stall_b",    m1_stall_o, 1'b1);
        tick(); s_ack_i = 1'b0; m0_cyc_i = 1'b0; #1;
        check("t1_cyc_drop",      s_cyc_o,    1'b0);
        tick(); #1;
        check("t1_idle_again",    m0_stall_o, 1'b1);

        // ---------------- 2: contention after reset ----------------
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; #1;
        tick(); #1;
        check("t2_m0_first",       m0_stall_o, 1'b0);
        check("t2_m1_waits",       m1_stall_o, 1'b1);
        check("t2_s_cyc",          s_cyc_o,    1'b1);
        tick(); m0_cyc_i = 1'b0; #1;
        check("t2_m0_release",     s_cyc_o,    1'b0);
        check("t2_m1_waits_b",     m1_stall_o, 1'b1);
        tick(); #1;
        check("t2_idle_gap",       m1_stall_o, 1'b1);
        check("t2_idle_gap_cyc",   s_cyc_o,    1'b0);
        tick(); m0_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 14'h0030; m1_we_i = 1'b0; #1;
        check("t2_m1_granted",     m1_stall_o, 1'b0);
        check("t2_m0_blocked",     m0_stall_o, 1'b1);
        check("t2_m1_stb",         s_stb_o,    1'b1);
        check_word("t2_m1_adr",    {18'b0, s_adr_o}, 32'h0000_0030);
        tick(); m1_stb_i = 1'b0; s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #1;
        check("t2_m1_ack",         m1_ack_o,   1'b1);
        check_word("t2_m1_dat",    m1_dat_o,   32'h1234_5678);
        check("t2_m0_no_ack",      m0_ack_o,   1'b0);
        tick(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; #1;
        check("t2_m1_release",     s_cyc_o,    1'b0);
        tick(); m1_cyc_i = 1'b1; #1;
        check("t2_idle2_m0",       m0_stall_o, 1'b1);
        tick(); #1;
        check("t2_rr_m0_again",    m0_stall_o, 1'b0);
        check("t2_rr_m1_waits",    m1_stall_o, 1'b1);
        tick(); m0_cyc_i = 1'b0; m1_cyc_i = 1'b0; #1;
        tick(); #1;
        check("t2_end_idle",       s_cyc_o,    1'b0);

        // ---------------- 3: m1 6-write burst, window fills ----------------
        tick(); m1_cyc_i = 1'b1; m1_we_i = 1'b1; #1;
        for (int i = 0; i < 11; i++) begin
            tick();
            m1_stb_i = burst[i].stb;
            m1_adr_i = burst[i].adr;
            m1_dat_i = 32'hA000_0000 + i;
            s_ack_i  = burst[i].ack;
            #1;
            check($sformatf("t3_stall_%0d", i), m1_stall_o, burst[i].x_stall);
            check($sformatf("t3_sstb_%0d", i),  s_stb_o,    burst[i].x_stb);
            check($sformatf("t3_ack_%0d", i),   m1_ack_o,   burst[i].x_ack);
            if (burst[i].x_stb) begin
                check_word($sformatf("t3_adr_%0d", i), {18'b0, s_adr_o}, {18'b0, burst[i].adr});
                check($sformatf("t3_we_%0d", i), s_we_o, 1'b1);
            end
        end
        tick(); m1_stb_i = 1'b0; s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_we_i = 1'b0; #1;
        check("t3_drained",        s_cyc_o,    1'b0);
        tick(); #1;
        check("t3_idle",           m1_stall_o, 1'b1);

        // ---------------- 4: m0 drops cyc with 2 in flight ----------------
        tick(); m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 14'h0040; #1;
        tick(); #1;
        check("t4_acc1_stb",       s_stb_o,    1'b1);
        check("t4_m0_granted",     m0_stall_o, 1'b0);
        check("t4_m1_waits",       m1_stall_o, 1'b1);
        tick(); m0_adr_i = 14'h0041; #1;
        check_word("t4_acc2_adr",  {18'b0, s_adr_o}, 32'h0000_0041);
        tick(); m0_stb_i = 1'b0; m0_cyc_i = 1'b0; #1;
        check("t4_cyc_held",       s_cyc_o,    1'b1);
        check("t4_no_stb",         s_stb_o,    1'b0);
        tick(); s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001; #1;
        check("t4_drain_m0_ack",   m0_ack_o,   1'b0);
        check("t4_drain_m1_ack",   m1_ack_o,   1'b0);
        check("t4_drain_cyc",      s_cyc_o,    1'b1);
        check("t4_drain_stb",      s_stb_o,    1'b0);
        check("t4_drain_m0_stall", m0_stall_o, 1'b1);
        check("t4_drain_m1_stall", m1_stall_o, 1'b1);
        tick(); s_dat_i = 32'hCAFE_0002; #1;
        check("t4_drain_m0_ack2",  m0_ack_o,   1'b0);
        check("t4_drain_m1_wait",  m1_stall_o, 1'b1);
        tick(); s_ack_i = 1'b0; #1;
        check("t4_idle_m1_wait",   m1_stall_o, 1'b1);
        check("t4_idle_cyc",       s_cyc_o,    1'b0);
        tick(); #1;
        check("t4_m1_granted",     m1_stall_o, 1'b0);
        check("t4_m0_blocked",     m0_stall_o, 1'b1);
        // Stray ack with nothing in flight: forwarded, but the count stays 0.
        tick(); s_ack_i = 1'b1; #1;
        check("t4_stray_fwd",      m1_ack_o,   1'b1);
        tick(); s_ack_i = 1'b0; m1_cyc_i = 1'b0; #1;
        check("t4_no_underflow",   s_cyc_o,    1'b0);
        tick(); #1;
        check("t4_no_drain",       s_cyc_o,    1'b0);

        // ---------------- 5: reset during a 3-beat burst ----------------
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 14'h0050; #1;
        tick(); #1;
        check("t5_beat1",          s_stb_o,    1'b1);
        tick(); m0_adr_i = 14'h0051; #1;
        tick(); m0_adr_i = 14'h0052; rst = 1'b1; #1;
        tick(); rst = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b1; #1;
        check("t5_s_cyc",          s_cyc_o,    1'b0);
        check("t5_s_stb",          s_stb_o,    1'b0);
        check("t5_m0_stall",       m0_stall_o, 1'b1);
        check("t5_m1_stall",       m1_stall_o, 1'b1);
        check("t5_ack_dropped",    m0_ack_o,   1'b0);
        tick(); s_ack_i = 1'b0; m1_cyc_i = 1'b1; #1;
        tick(); #1;
        check("t5_m1_granted",     m1_stall_o, 1'b0);
        tick(); m1_cyc_i = 1'b0; #1;
        check("t5_count_zero",     s_cyc_o,    1'b0);
        tick(); #1;

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- 6: watchdog, RAM never acks ----------------
        tick(); m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 14'h0060; m0_we_i = 1'b0; #1;
        tick(); #1;
        check("t6_accept",         s_stb_o,    1'b1);
        tick(); m0_stb_i = 1'b0; #1;
        check("t6_wait_1",         m0_err_o,   1'b0);
        for (int i = 2; i < 8; i++) begin
            tick(); #1;
            check($sformatf("t6_wait_%0d", i), m0_err_o, 1'b0);
        end
        tick(); #1;
        check("t6_err_pulse",      m0_err_o,   1'b1);
        check("t6_m1_no_err",      m1_err_o,   1'b0);
        tick(); #1;
        check("t6_err_single",     m0_err_o,   1'b0);
        check("t6_window_clear",   m0_stall_o, 1'b0);
        tick(); m0_cyc_i = 1'b0; #1;
        check("t6_release",        s_cyc_o,    1'b0);
        tick(); #1;
        check("t6_idle",           m0_stall_o, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
